udp_pixel_decoder: RTL and testbench

//  Upstream stage of the ledpanel array. Consumes the LiteEth UDP0 source byte stream and decodes framed

---
 rtl/udp_pixel_decoder_pkg.sv | 32 +++
 rtl/udp_pixel_decoder_sat_counter.sv | 23 ++
 rtl/udp_pixel_decoder.sv | 155 +++++++++++++++
 tb/tb_udp_pixel_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pixel_decoder_pkg.sv
// Shared protocol constants and types for the UDP pixel decoder and ledpanel blocks.
// Frame layout: MAGIC, OPCODE, PANEL_MASK, ADDR_HI, ADDR_LO, payload.
package udp_pixel_decoder_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hC5;
    localparam logic [7:0] OP_PIXEL      = 8'h01;
    localparam logic [7:0] OP_LED        = 8'h02;
    localparam logic [3:0] CTRL_WR_PIXEL = 4'b0001;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OP,
        ST_MASK,
        ST_AHI,
        ST_ALO,
        ST_PR,
        ST_PG,
        ST_PB,
        ST_LEDB,
        ST_DROP
    } state_t;

    // Build a mask with the low 'count' bits set, so that strobes never reach absent panels.
    function automatic logic [7:0] panelMask(input int count);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/udp_pixel_decoder_sat_counter.sv
// Saturating event counter: it counts up by one per i_inc pulse and then holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/udp_pixel_decoder.sv
// This module decodes framed UDP bytes into one-cycle pixel-write strobes on the ctrl bus.
// It also drives the status LED and the counters for good and bad frames.
module udp_pixel_decoder
    import udp_pixel_decoder_pkg::*;
#(
    parameter int         PANEL_COUNT = 6,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        udp0_source_valid,
    input  logic        udp0_source_last,
    output logic        udp0_source_ready,
    input  logic [7:0]  udp0_source_data,
    input  logic        udp0_source_error,
    output logic [7:0]  ctrl_en,
    output logic [3:0]  ctrl_wr,
    output logic [15:0] ctrl_addr,
    output logic [23:0] ctrl_wdat,
    output logic        led_reg,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count
);

    localparam logic [7:0] PANEL_MASK = panelMask(PANEL_COUNT);

    state_t      r_state;
    logic        r_isLed;
    logic        r_ledDone;
    logic [7:0]  r_mask;
    logic [15:0] r_addr;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_ctrlEn;
    logic [3:0]  r_ctrlWr;
    logic [15:0] r_ctrlAddr;
    logic [23:0] r_ctrlWdat;
    logic        r_led;

    logic        w_accept;
    logic        w_lastAccept;
    logic        w_goodEnd;
    logic        w_errEnd;
    logic [7:0]  w_strobeEn;

    assign udp0_source_ready = ~reset;
    assign w_accept          = udp0_source_valid & udp0_source_ready;
    assign w_lastAccept      = w_accept & udp0_source_last;
    assign w_strobeEn        = r_mask & PANEL_MASK;

    // A frame is good only if it ends on a completed pixel triple or inside the LED payload.
    assign w_goodEnd = w_lastAccept & ~udp0_source_error &
                       ((r_state == ST_PB) || (r_state == ST_LEDB));
    assign w_errEnd  = w_lastAccept & ~w_goodEnd;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_isLed    <= 1'b0;
            r_ledDone  <= 1'b0;
            r_mask     <= '0;
            r_addr     <= '0;
            r_red      <= '0;
            r_green    <= '0;
            r_ctrlEn   <= '0;
            r_ctrlWr   <= '0;
            r_ctrlAddr <= '0;
            r_ctrlWdat <= '0;
            r_led      <= 1'b0;
        end else begin
            r_ctrlEn <= '0;
            r_ctrlWr <= '0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: r_state <= (udp0_source_data == MAGIC) ? ST_OP : ST_DROP;
                    ST_OP: begin
                        if (udp0_source_data == OP_PIXEL) begin
                            r_isLed <= 1'b0;
                            r_state <= ST_MASK;
                        end else if (udp0_source_data == OP_LED) begin
                            r_isLed <= 1'b1;
                            r_state <= ST_MASK;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                    ST_MASK: begin
                        r_mask  <= udp0_source_data;
                        r_state <= ST_AHI;
                    end
                    ST_AHI: begin
                        r_addr[15:8] <= udp0_source_data;
                        r_state      <= ST_ALO;
                    end
                    ST_ALO: begin
                        r_addr[7:0] <= udp0_source_data;
                        r_ledDone   <= 1'b0;
                        r_state     <= r_isLed ? ST_LEDB : ST_PR;
                    end
                    ST_PR: begin
                        r_red   <= udp0_source_data;
                        r_state <= ST_PG;
                    end
                    ST_PG: begin
                        r_green <= udp0_source_data;
                        r_state <= ST_PB;
                    end
                    ST_PB: begin
                        // A masked-off frame still advances the address but leaves the bus untouched.
                        if (w_strobeEn != 8'h00) begin
                            r_ctrlEn   <= w_strobeEn;
                            r_ctrlWr   <= CTRL_WR_PIXEL;
                            r_ctrlAddr <= r_addr;
                            r_ctrlWdat <= {r_red, r_green, udp0_source_data};
                        end
                        r_addr  <= r_addr + 16'd1;
                        r_state <= ST_PR;
                    end
                    ST_LEDB: begin
                        if (!r_ledDone) begin
                            r_led     <= udp0_source_data[0];
                            r_ledDone <= 1'b1;
                        end
                    end
                    ST_DROP: r_state <= ST_DROP;
                    default: r_state <= ST_IDLE;
                endcase
                if (udp0_source_last) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    sat_counter #(.WIDTH(16)) u_pktCounter (
        .clock  (clock),
        .reset  (reset),
        .i_inc  (w_goodEnd),
        .o_count(pkt_count)
    );

    sat_counter #(.WIDTH(8)) u_errCounter (
        .clock  (clock),
        .reset  (reset),
        .i_inc  (w_errEnd),
        .o_count(err_count)
    );

    assign ctrl_en   = r_ctrlEn;
    assign ctrl_wr   = r_ctrlWr;
    assign ctrl_addr = r_ctrlAddr;
    assign ctrl_wdat = r_ctrlWdat;
    assign led_reg   = r_led;

endmodule

// File: tb/tb_udp_pixel_decoder.sv
// Self-checking bench for udp_pixel_decoder: a frame-position model is compared against the DUT every cycle,
// and directed frames are pinned with literal expectations.
module tb_udp_pixel_decoder;

    logic        clock;
    logic        reset;
    logic        valid;
    logic        last;
    logic        error;
    logic [7:0]  data;
    logic        ready;
    logic [7:0]  ctrlEn;
    logic [3:0]  ctrlWr;
    logic [15:0] ctrlAddr;
    logic [23:0] ctrlWdat;
    logic        ledReg;
    logic [15:0] pktCount;
    logic [7:0]  errCount;

    udp_pixel_decoder dut (
        .clock            (clock),
        .reset            (reset),
        .udp0_source_valid(valid),
        .udp0_source_last (last),
        .udp0_source_ready(ready),
        .udp0_source_data (data),
        .udp0_source_error(error),
        .ctrl_en          (ctrlEn),
        .ctrl_wr          (ctrlWr),
        .ctrl_addr        (ctrlAddr),
        .ctrl_wdat        (ctrlWdat),
        .led_reg          (ledReg),
        .pkt_count        (pktCount),
        .err_count        (errCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  en;
        logic [15:0] addr;
        logic [23:0] wdat;
    } strobe_t;

    int          total = 0;
    int          bad = 0;
    logic        checkEn = 1'b0;
    strobe_t     strobeLog[$];
    logic [7:0]  frm[$];

    // Model state: position inside the current frame plus the values it implies.
    int          mPos;
    logic        mBad, mPix, mLed;
    logic [7:0]  mMask, mR, mG;
    logic [15:0] mBase;
    int          mPkt, mErr;
    logic        expLed;
    logic        expStrobe;
    logic [7:0]  expEn;
    logic [15:0] expCtrlAddr;
    logic [23:0] expCtrlWdat;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mPos = 0; mBad = 1'b0; mPix = 1'b0; mLed = 1'b0;
        mMask = '0; mR = '0; mG = '0; mBase = '0;
        mPkt = 0; mErr = 0; expLed = 1'b0;
        expStrobe = 1'b0; expEn = '0; expCtrlAddr = '0; expCtrlWdat = '0;
    endtask

    task automatic modelByte(input logic [7:0] d, input logic l, input logic e);
        int p;
        logic good;
        if (mPos == 0) begin
            mBad = (d != 8'hC5); mPix = 1'b0; mLed = 1'b0;
        end else if (mPos == 1 && !mBad) begin
            if (d == 8'h01) mPix = 1'b1;
            else if (d == 8'h02) mLed = 1'b1;
            else mBad = 1'b1;
        end else if (mPos == 2) mMask = d;
        else if (mPos == 3) mBase[15:8] = d;
        else if (mPos == 4) mBase[7:0] = d;
        else if (!mBad) begin
            p = mPos - 5;
            if (mPix) begin
                if (p % 3 == 0) mR = d;
                else if (p % 3 == 1) mG = d;
                else if ((mMask & 8'h3F) != 8'h00) begin
                    expStrobe   = 1'b1;
                    expEn       = mMask & 8'h3F;
                    expCtrlAddr = mBase + 16'(p / 3);
                    expCtrlWdat = {mR, mG, d};
                end
            end
            if (mLed && p == 0) expLed = d[0];
        end
        if (l) begin
            good = !e && !mBad && (mPos >= 5) && (mLed || (mPix && ((mPos - 5) % 3 == 2)));
            if (good) mPkt = (mPkt < 65535) ? mPkt + 1 : 65535;
            else mErr = (mErr < 255) ? mErr + 1 : 255;
            mPos = 0;
        end else begin
            mPos++;
        end
    endtask

    // Drive one cycle of inputs and advance the model by whatever the DUT accepts on that edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic e);
        valid = v; data = d; last = l; error = e;
        @(posedge clock);
        expStrobe = 1'b0;
        if (reset) modelReset();
        else if (v) modelByte(d, l, e);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic sendFrame(input int gapMax, input logic errLast);
        for (int i = 0; i < frm.size(); i++) begin
            if (gapMax > 0) idleCycles(int'($urandom_range(gapMax, 0)));
            applyStimulus(1'b1, frm[i], i == frm.size() - 1, errLast && (i == frm.size() - 1));
        end
        idleCycles(2);
    endtask

    task automatic checkStrobe(input string name, input int idx, input logic [7:0] en,
                               input logic [15:0] addr, input logic [23:0] wdat);
        strobe_t s;
        if (idx >= strobeLog.size()) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: strobe %0d missing, got %0d strobes", name, idx, strobeLog.size());
        end else begin
            s = strobeLog[idx];
            checkOutput({name, ".en"}, 32'(s.en), 32'(en));
            checkOutput({name, ".addr"}, 32'(s.addr), 32'(addr));
            checkOutput({name, ".wdat"}, 32'(s.wdat), 32'(wdat));
        end
    endtask

    // Per-cycle comparison of every output against the model, sampled away from the active edge.
    always @(negedge clock) begin
        if (checkEn) begin
            if (ctrlEn != 8'h00) strobeLog.push_back({ctrlEn, ctrlAddr, ctrlWdat});
            checkOutput("ready", 32'(ready), 32'(!reset));
            checkOutput("ctrl_en", 32'(ctrlEn), 32'(expStrobe ? expEn : 8'h00));
            checkOutput("ctrl_wr", 32'(ctrlWr), 32'(expStrobe ? 4'b0001 : 4'b0000));
            checkOutput("ctrl_addr", 32'(ctrlAddr), 32'(expCtrlAddr));
            checkOutput("ctrl_wdat", 32'(ctrlWdat), 32'(expCtrlWdat));
            checkOutput("led_reg", 32'(ledReg), 32'(expLed));
            checkOutput("pkt_count", 32'(pktCount), 32'(mPkt));
            checkOutput("err_count", 32'(errCount), 32'(mErr));
        end
    end

    initial begin
        int mark;
        reset = 1'b1; valid = 1'b0; last = 1'b0; error = 1'b0; data = 8'h00;
        modelReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkEn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        idleCycles(1);
        checkOutput("reset.pkt", 32'(pktCount), 32'd0);
        checkOutput("reset.en", 32'(ctrlEn), 32'd0);

        mark = strobeLog.size();
        frm = '{8'hC5, 8'h01, 8'h03, 8'h00, 8'h10, 8'hFF, 8'h00, 8'h80};
        sendFrame(0, 1'b0);
        checkOutput("t1.count", strobeLog.size() - mark, 1);
        checkStrobe("t1", mark, 8'h03, 16'h0010, 24'hFF0080);
        checkOutput("t1.pkt", 32'(pktCount), 32'd1);

        mark = strobeLog.size();
        frm = '{8'hC5, 8'h01, 8'h3F, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        sendFrame(0, 1'b0);
        checkStrobe("t2.wrapA", mark, 8'h3F, 16'hFFFF, 24'h010203);
        checkStrobe("t2.wrapB", mark + 1, 8'h3F, 16'h0000, 24'h040506);
        mark = strobeLog.size();
        frm = '{8'hC5, 8'h01, 8'hC0, 8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC};
        sendFrame(0, 1'b0);
        checkOutput("t2.nostrobe", strobeLog.size() - mark, 0);
        checkOutput("t2.pkt", 32'(pktCount), 32'd3);

        mark = strobeLog.size();
        frm = '{8'hC5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        sendFrame(0, 1'b0);
        checkStrobe("t3", mark, 8'h01, 16'h0000, 24'h112233);
        checkOutput("t3.err", 32'(errCount), 32'd1);

        mark = strobeLog.size();
        frm = '{8'h5A, 8'h01, 8'h03, 8'h00, 8'h10, 8'hFF, 8'h00, 8'h80};
        sendFrame(0, 1'b0);
        checkOutput("t4.nostrobe", strobeLog.size() - mark, 0);
        frm = '{8'hC5, 8'h01, 8'h02, 8'h12, 8'h34, 8'h0A, 8'h0B, 8'h0C};
        sendFrame(0, 1'b0);
        checkStrobe("t4", mark, 8'h02, 16'h1234, 24'h0A0B0C);
        checkOutput("t4.err", 32'(errCount), 32'd2);
        checkOutput("t4.pkt", 32'(pktCount), 32'd4);

        frm = '{8'hC5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
        sendFrame(0, 1'b0);
        checkOutput("t5.ledOn", 32'(ledReg), 32'd1);
        frm = '{8'hC5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(0, 1'b0);
        checkOutput("t5.ledOff", 32'(ledReg), 32'd0);
        checkOutput("t5.pkt", 32'(pktCount), 32'd6);
        frm = '{8'hC5, 8'h07, 8'h00, 8'h11};
        sendFrame(0, 1'b0);
        checkOutput("t5.err", 32'(errCount), 32'd3);
        mark = strobeLog.size();
        frm = '{8'hC5, 8'h01, 8'h01, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03};
        sendFrame(0, 1'b1);
        checkStrobe("t5.errB", mark, 8'h01, 16'h0005, 24'h010203);
        checkOutput("t5.errB.err", 32'(errCount), 32'd4);

        frm = '{8'hC5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
        sendFrame(3, 1'b0);
        mark = strobeLog.size();
        frm = '{8'hC5, 8'h01, 8'h07, 8'h00, 8'h40, 8'h12, 8'h34};
        for (int i = 0; i < frm.size(); i++) begin
            idleCycles(int'($urandom_range(3, 0)));
            applyStimulus(1'b1, frm[i], 1'b0, 1'b0);
        end
        reset = 1'b1;
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("t6.rstEn", 32'(ctrlEn), 32'd0);
        checkOutput("t6.rstAddr", 32'(ctrlAddr), 32'd0);
        checkOutput("t6.rstLed", 32'(ledReg), 32'd0);
        checkOutput("t6.rstPkt", 32'(pktCount), 32'd0);
        frm = '{8'h33, 8'h44, 8'h55};
        sendFrame(2, 1'b0);
        checkOutput("t6.nostrobe", strobeLog.size() - mark, 0);
        checkOutput("t6.resErr", 32'(errCount), 32'd1);
        frm = '{8'hC5, 8'h01, 8'h21, 8'h00, 8'h08, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        sendFrame(3, 1'b0);
        checkStrobe("t6.a", mark, 8'h21, 16'h0008, 24'h102030);
        checkStrobe("t6.b", mark + 1, 8'h21, 16'h0009, 24'h405060);
        checkOutput("t6.pkt", 32'(pktCount), 32'd1);

        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("sat.err", 32'(errCount), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
